// File: rtl/pair_cover_pkg.sv
// rtl/pair_cover_pkg.sv - shared constants, mode enum and index-width helper for the pair-cover pipeline
package pair_cover_pkg;

  localparam int DEF_NUM_GROUPS  = 4;
  localparam int DEF_GROUP_WIDTH = 16;
  localparam int DEF_CNT_W       = 8;

  typedef enum logic {
    MODE_SINGLE = 1'b0,
    MODE_ACCUM  = 1'b1
  } mode_e;

  // Width of an index into a group; a group is always at least 2 bits wide.
  function automatic int idx_w(input int gw);
    return (gw > 1) ? $clog2(gw) : 1;
  endfunction

endpackage

// File: rtl/group_cover_reduce.sv
// rtl/group_cover_reduce.sv - per-group AND-reduce and lowest-uncovered-bit encoder
module group_cover_reduce
  import pair_cover_pkg::*;
#(
  parameter  int GROUP_WIDTH = DEF_GROUP_WIDTH,
  localparam int IDX_W       = idx_w(GROUP_WIDTH)
) (
  input  logic [GROUP_WIDTH-1:0] i_cov,
  output logic                   o_all,
  output logic [IDX_W-1:0]       o_miss_idx
);

  // Scan from the top down so the lowest uncovered bit is the last one written.
  always_comb begin
    o_all      = &i_cov;
    o_miss_idx = '0;
    for (int i = GROUP_WIDTH - 1; i >= 0; i--) begin
      if (!i_cov[i]) begin
        o_miss_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/pair_cover_reduce_pipe.sv
// rtl/pair_cover_reduce_pipe.sv - two-stage pair-cover checker with frame accumulation and valid/ready flow control
module pair_cover_reduce_pipe
  import pair_cover_pkg::*;
#(
  parameter  int NUM_GROUPS  = DEF_NUM_GROUPS,
  parameter  int GROUP_WIDTH = DEF_GROUP_WIDTH,
  parameter  int CNT_W       = DEF_CNT_W,
  localparam int IDX_W       = idx_w(GROUP_WIDTH),
  localparam int VEC_W       = NUM_GROUPS * GROUP_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [VEC_W-1:0]            in_a,
  input  logic [VEC_W-1:0]            in_b,
  input  logic                        in_last,
  input  logic                        mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_GROUPS-1:0]       out_all,
  output logic [NUM_GROUPS*IDX_W-1:0] out_miss_idx,
  output logic [CNT_W-1:0]            out_beats
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Open-frame state
  logic [VEC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_frame_open;
  mode_e            r_mode;

  // Stage 1
  logic             r_s1_valid;
  logic [VEC_W-1:0] r_s1_cov;
  logic [CNT_W-1:0] r_s1_cnt;

  // Stage 2 (output register)
  logic                        r_out_valid;
  logic [NUM_GROUPS-1:0]       r_out_all;
  logic [NUM_GROUPS*IDX_W-1:0] r_out_miss;
  logic [CNT_W-1:0]            r_out_beats;

  logic                        w_s2_free;
  logic                        w_s1_adv;
  logic                        w_in_ready;
  logic                        w_accept;
  mode_e                       w_mode;
  logic                        w_closing;
  logic [VEC_W-1:0]            w_cov_next;
  logic [CNT_W-1:0]            w_cnt_next;
  logic [NUM_GROUPS-1:0]       w_grp_all;
  logic [NUM_GROUPS*IDX_W-1:0] w_grp_miss;

  // The mode seen by the first beat of a frame governs the whole frame.
  assign w_mode     = r_frame_open ? r_mode : mode_e'(mode);
  assign w_closing  = (w_mode == MODE_SINGLE) | in_last;
  assign w_cov_next = r_acc | in_a | in_b;
  assign w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  assign w_s2_free  = !r_out_valid | out_ready;
  assign w_s1_adv   = r_s1_valid & w_s2_free;
  assign w_in_ready = !rst & (!r_s1_valid | w_s2_free);
  assign w_accept   = in_valid & w_in_ready;

  assign in_ready     = w_in_ready;
  assign out_valid    = r_out_valid;
  assign out_all      = r_out_all;
  assign out_miss_idx = r_out_miss;
  assign out_beats    = r_out_beats;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    group_cover_reduce #(
      .GROUP_WIDTH(GROUP_WIDTH)
    ) u_reduce (
      .i_cov     (r_s1_cov[g*GROUP_WIDTH +: GROUP_WIDTH]),
      .o_all     (w_grp_all[g]),
      .o_miss_idx(w_grp_miss[g*IDX_W +: IDX_W])
    );
  end

  // Accumulate coverage and count beats of the open frame; a closing beat hands both to stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_frame_open <= 1'b0;
      r_mode       <= MODE_SINGLE;
    end else if (w_accept) begin
      if (w_closing) begin
        r_acc        <= '0;
        r_cnt        <= '0;
        r_frame_open <= 1'b0;
      end else begin
        r_acc        <= w_cov_next;
        r_cnt        <= w_cnt_next;
        r_frame_open <= 1'b1;
        r_mode       <= w_mode;
      end
    end
  end

  // Stage 1 loads a finished frame; in_ready guarantees it is empty or draining that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_cov   <= '0;
      r_s1_cnt   <= '0;
    end else if (w_accept && w_closing) begin
      r_s1_valid <= 1'b1;
      r_s1_cov   <= w_cov_next;
      r_s1_cnt   <= w_cnt_next;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Output register captures the reduced stage-1 frame and holds it until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_all   <= '0;
      r_out_miss  <= '0;
      r_out_beats <= '0;
    end else if (w_s1_adv) begin
      r_out_valid <= 1'b1;
      r_out_all   <= w_grp_all;
      r_out_miss  <= w_grp_miss;
      r_out_beats <= r_s1_cnt;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pair_cover_reduce_pipe.sv
// tb/tb_pair_cover_reduce_pipe.sv - self-checking bench for pair_cover_reduce_pipe
module tb_pair_cover_reduce_pipe;

  logic        clk = 1'b0;
  logic        rst;
  int          n_tests = 0;
  int          n_fail  = 0;

  // DUT A: default parameters
  logic        in_valid, in_ready, in_last, mode, out_valid, out_ready;
  logic [63:0] in_a, in_b;
  logic [3:0]  out_all;
  logic [15:0] out_miss_idx;
  logic [7:0]  out_beats;

  // DUT B: CNT_W = 2
  logic        b_in_valid, b_in_ready, b_in_last, b_mode, b_out_valid, b_out_ready;
  logic [63:0] b_in_a, b_in_b;
  logic [3:0]  b_out_all;
  logic [15:0] b_out_miss_idx;
  logic [1:0]  b_out_beats;

  always #5 clk = ~clk;

  pair_cover_reduce_pipe u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_all(out_all),
    .out_miss_idx(out_miss_idx), .out_beats(out_beats)
  );

  pair_cover_reduce_pipe #(.CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_a(b_in_a), .in_b(b_in_b),
    .in_last(b_in_last), .mode(b_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_all(b_out_all),
    .out_miss_idx(b_out_miss_idx), .out_beats(b_out_beats)
  );

  // Reference: a group passes when all 16 of its bits are covered.
  function automatic logic [3:0] ref_all(input logic [63:0] cov);
    logic [3:0] r;
    for (int g = 0; g < 4; g++) r[g] = (cov[g*16 +: 16] == 16'hFFFF);
    return r;
  endfunction

  // Reference: first uncovered bit counting upward from bit 0, 0 when none.
  function automatic logic [15:0] ref_miss(input logic [63:0] cov);
    logic [15:0] r;
    int idx;
    r = '0;
    for (int g = 0; g < 4; g++) begin
      idx = 0;
      for (int i = 0; i < 16; i++) begin
        if (cov[g*16 + i] == 1'b0) begin
          idx = i;
          break;
        end
      end
      r[g*4 +: 4] = idx[3:0];
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 0; in_last = 0; mode = 0; out_ready = 1; in_a = '0; in_b = '0;
    b_in_valid = 0; b_in_last = 0; b_mode = 0; b_out_ready = 1; b_in_a = '0; b_in_b = '0;
    tick(); tick();
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_all !== 4'h0 || out_miss_idx !== 16'h0 || out_beats !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b all=%h miss=%h beats=%h, want all zero",
               out_valid, out_all, out_miss_idx, out_beats);
    end
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    n_tests++;
    if (b_out_valid !== 1'b0 || b_out_beats !== 2'h0 || b_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dut_b: got valid=%b beats=%h in_ready=%b want 0/0/0",
               b_out_valid, b_out_beats, b_in_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_full;
    in_valid = 1; mode = 0; in_last = 0; in_a = '1; in_b = '0; out_ready = 1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_full_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_full_early: got out_valid %b want 0", out_valid); end
    tick();
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_all !== 4'b1111 || out_miss_idx !== 16'h0 || out_beats !== 8'd1) begin
      n_fail++;
      $display("FAIL single_full_result: got valid=%b all=%b miss=%h beats=%0d want 1/1111/0000/1",
               out_valid, out_all, out_miss_idx, out_beats);
    end
    tick();
  endtask

  task automatic test_single_miss;
    in_valid = 1; mode = 0; in_last = 0; out_ready = 1;
    in_a = 64'hFFFF_FFFF_FFFF_FFFB; in_b = 64'h0001_0000_0000_0000;
    tick();
    in_valid = 0;
    tick();
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_all !== 4'b1110 || out_miss_idx !== 16'h0002 || out_beats !== 8'd1) begin
      n_fail++;
      $display("FAIL single_miss_result: got valid=%b all=%b miss=%h beats=%0d want 1/1110/0002/1",
               out_valid, out_all, out_miss_idx, out_beats);
    end
    tick();
  endtask

  task automatic test_accum;
    in_valid = 1; mode = 1; in_last = 0; out_ready = 1;
    in_a = 64'h00FF_00FF_00FF_00FF; in_b = '0;
    tick();
    in_a = 64'hFF00_FF00_FF00_FF00; in_last = 1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL accum_beat1_valid: got %b want 0", out_valid); end
    tick();
    in_valid = 0; in_last = 0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL accum_early: got %b want 0", out_valid); end
    tick();
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_all !== 4'b1111 || out_miss_idx !== 16'h0 || out_beats !== 8'd2) begin
      n_fail++;
      $display("FAIL accum_result: got valid=%b all=%b miss=%h beats=%0d want 1/1111/0000/2",
               out_valid, out_all, out_miss_idx, out_beats);
    end
    tick();
    mode = 0;
  endtask

  task automatic test_backpressure;
    logic [63:0] v [3];
    logic        ok;
    v[0] = 64'hFFFF_FFFF_FFFF_FFF7;
    v[1] = 64'hFFFF_FFFF_FEFF_FFFF;
    v[2] = 64'h7FFF_FFFF_FFFF_FFFF;
    mode = 0; in_last = 0; in_b = '0; out_ready = 0;
    in_valid = 1; in_a = v[0];
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_beat1_ready: got %b want 1", in_ready); end
    tick();
    in_a = v[1];
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_beat2_ready: got %b want 1", in_ready); end
    tick();
    in_a = v[2];
    for (int c = 0; c < 2; c++) begin
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_beat3_stall: cycle %0d got in_ready %b want 0", c, in_ready); end
      n_tests++;
      if (out_valid !== 1'b1 || out_miss_idx !== ref_miss(v[0])) begin
        n_fail++;
        $display("FAIL bp_hold: got valid=%b miss=%h want 1/%h", out_valid, out_miss_idx, ref_miss(v[0]));
      end
      tick();
    end
    out_ready = 1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_resume_ready: got %b want 1", in_ready); end
    for (int k = 0; k < 3; k++) begin
      #1;
      ok = (out_valid === 1'b1) && (out_all === ref_all(v[k])) &&
           (out_miss_idx === ref_miss(v[k])) && (out_beats === 8'd1);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL bp_order_%0d: got valid=%b all=%b miss=%h beats=%0d want 1/%b/%h/1",
                 k, out_valid, out_all, out_miss_idx, out_beats, ref_all(v[k]), ref_miss(v[k]));
      end
      tick();
      in_valid = 0;
    end
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_frame;
    in_valid = 1; mode = 1; in_last = 0; in_a = '1; in_b = '0; out_ready = 1;
    tick();
    in_valid = 0; rst = 1;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 0", in_ready); end
    tick();
    rst = 0; in_valid = 1; mode = 0; in_a = '0; in_b = '0;
    tick();
    in_valid = 0;
    tick();
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_all !== 4'b0000 || out_miss_idx !== 16'h0 || out_beats !== 8'd1) begin
      n_fail++;
      $display("FAIL rstmid_result: got valid=%b all=%b miss=%h beats=%0d want 1/0000/0000/1",
               out_valid, out_all, out_miss_idx, out_beats);
    end
    tick();
  endtask

  task automatic test_saturate;
    logic [63:0] cov;
    cov = '0;
    b_in_b = '0; b_out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      b_in_valid = 1;
      b_in_a     = {$urandom, $urandom};
      b_mode     = (k == 2 || k == 3) ? 1'b0 : 1'b1;
      b_in_last  = (k == 4);
      cov        = cov | b_in_a;
      #1;
      n_tests++;
      if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_beat_%0d: got in_ready=%b out_valid=%b want 1/0", k, b_in_ready, b_out_valid);
      end
      tick();
    end
    b_in_valid = 0; b_in_last = 0;
    #1;
    n_tests++;
    if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_early: got %b want 0", b_out_valid); end
    tick();
    #1;
    n_tests++;
    if (b_out_valid !== 1'b1 || b_out_beats !== 2'd3 || b_out_all !== ref_all(cov) ||
        b_out_miss_idx !== ref_miss(cov)) begin
      n_fail++;
      $display("FAIL sat_result: got valid=%b beats=%0d all=%b miss=%h want 1/3/%b/%h",
               b_out_valid, b_out_beats, b_out_all, b_out_miss_idx, ref_all(cov), ref_miss(cov));
    end
    tick();
  endtask

  task automatic test_random;
    logic [63:0] q_cov[$];
    int          q_cnt[$];
    logic [63:0] m_cov, e_cov;
    int          m_cnt, e_cnt;
    logic        m_open, m_mode, eff_mode, exp_rdy;
    m_cov = '0; m_cnt = 0; m_open = 0; m_mode = 0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      if (cyc < 400) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_a      = {$urandom, $urandom} | {$urandom, $urandom};
        in_b      = {$urandom, $urandom} | {$urandom, $urandom};
        mode      = $urandom_range(0, 1);
        in_last   = ($urandom_range(0, 2) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = m_open;
        in_a      = '0; in_b = '0;
        mode      = 1; in_last = 1; out_ready = 1;
      end
      #1;
      exp_rdy = !(q_cov.size() == 2 && !out_ready);
      n_tests++;
      if (in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rand_in_ready: cycle %0d got %b want %b", cyc, in_ready, exp_rdy);
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_tests++;
        if (q_cov.size() == 0) begin
          n_fail++;
          $display("FAIL rand_spurious: cycle %0d got out_valid 1 want no pending frame", cyc);
        end else begin
          e_cov = q_cov.pop_front();
          e_cnt = q_cnt.pop_front();
          if (out_all !== ref_all(e_cov) || out_miss_idx !== ref_miss(e_cov) || out_beats !== e_cnt[7:0]) begin
            n_fail++;
            $display("FAIL rand_result: cycle %0d got all=%b miss=%h beats=%0d want %b/%h/%0d",
                     cyc, out_all, out_miss_idx, out_beats, ref_all(e_cov), ref_miss(e_cov), e_cnt);
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        eff_mode = m_open ? m_mode : mode;
        m_cov    = m_cov | in_a | in_b;
        m_cnt    = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (eff_mode == 1'b0 || in_last) begin
          q_cov.push_back(m_cov);
          q_cnt.push_back(m_cnt);
          m_cov = '0; m_cnt = 0; m_open = 0;
        end else begin
          m_open = 1;
          m_mode = eff_mode;
        end
      end
      tick();
    end
    in_valid = 0;
    n_tests++;
    if (q_cov.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_drain: got %0d pending frames, out_valid=%b want 0/0", q_cov.size(), out_valid);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    test_reset();
    test_single_full();
    test_single_miss();
    test_accum();
    test_backpressure();
    test_reset_mid_frame();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pair_cover_reduce_pipe.md
Name: pair_cover_reduce_pipe

Overview:
- Parametrised, pipelined pair-cover checker: per bit, cover = a | b; per group, reports whether every bit is covered and the lowest uncovered bit index.
- Generalises the fixed 4-group x 16-pair combinational cover/AND-reduce logic: configurable group count and width, valid/ready handshake, and an accumulate mode that ORs coverage across multi-beat frames.
- Sits between the pair-vector producers and the status/result collector.

Parameters:
- NUM_GROUPS, 4, number of independent reduction groups (>=1).
- GROUP_WIDTH, 16, bit pairs per group (>=2).
- CNT_W, 8, width of the saturating beat counter.
- IDX_W, derived as clog2(GROUP_WIDTH); not overridable.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_a  in  NUM_GROUPS*GROUP_WIDTH  first vector of each pair; group g occupies bits [g*GROUP_WIDTH +: GROUP_WIDTH].
- in_b  in  NUM_GROUPS*GROUP_WIDTH  second vector of each pair; same layout as in_a.
- in_last  in  1  closes a frame; ignored in single mode.
- mode  in  1  0 = single (each beat is a frame), 1 = accumulate.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_all  out  NUM_GROUPS  bit g = every bit of group g covered.
- out_miss_idx  out  NUM_GROUPS*IDX_W  lowest uncovered index per group; 0 when the group is fully covered.
- out_beats  out  CNT_W  beats in the frame, saturating.

Behaviour:
- Reset:
  - out_valid=0; out_all, out_miss_idx and out_beats = 0.
  - Accumulator, beat counter, stage-1 valid and frame-open flag cleared.
  - in_ready is forced 0 while rst=1.
- Handshake:
  - A beat is accepted when in_valid & in_ready.
  - A result is consumed when out_valid & out_ready.
  - Outputs are held stable while out_valid & !out_ready.
- Accumulate path:
  - acc (NUM_GROUPS*GROUP_WIDTH) holds the running OR of (in_a | in_b) for the open frame.
  - On an accepted beat: if it is a closing beat, (acc | in_a | in_b) is loaded into stage 1 and acc is cleared. Otherwise acc <= acc | in_a | in_b.
  - Closing beat = mode==0, or mode==1 & in_last.
- Mode latching:
  - mode is sampled on the first beat of a frame.
  - A mode change mid-frame has no effect until the next frame.
- Beat counter:
  - Counts accepted beats of the frame, saturating at 2^CNT_W-1.
  - Its value moves with the frame into stage 1 and is reset for the next frame.
- Stage 1 (s1): registered coverage vector, beat count, s1_valid.
- Stage 2 (output register):
  - Per group: out_all = AND of coverage bits.
  - out_miss_idx = priority encode (lowest index) of ~coverage.
- Flow control:
  - s2_free = !out_valid | out_ready.
  - s1 moves to the output when s1_valid & s2_free.
  - in_ready = !rst & (!s1_valid | s2_free).
  - in_ready applies to all beats, including non-closing beats, for uniformity.
- Latency: a closing beat accepted at cycle t gives out_valid at t+2 when there is no backpressure.
- Throughput: one frame per cycle in single mode.
- Simultaneous events:
  - Consuming the output and moving s1 in the same cycle is allowed.
  - Loading s1 from a closing beat while s1 moves out in the same cycle is allowed.
- Ordering: frames are never reordered or dropped; there is no overflow path.
- Reset mid-frame: any partial frame, in-flight s1 data and the output are discarded.

Decomposition:
- Shared package pair_cover_pkg:
  - Default parameter constants.
  - mode enum (MODE_SINGLE=0, MODE_ACCUM=1).
  - clog2-based IDX_W function.
- Sub-module group_cover_reduce:
  - Combinational AND-reduce plus lowest-zero priority encoder for one group.
  - Instantiated NUM_GROUPS times in the stage-2 input logic.

Test Plan:
1. Single mode, in_a=64'hFFFF_FFFF_FFFF_FFFF, in_b=0 at t -> out_valid at t+2, out_all=4'b1111, out_miss_idx all 0, out_beats=1.
2. Single mode, in_a=64'hFFFF_FFFF_FFFF_FFFB, in_b=64'h0001_0000_0000_0000 -> out_all=4'b1110, miss_idx[0]=2, groups 1..3 idx=0.
3. Accumulate mode:
   - Beats: in_a=64'h00FF00FF00FF00FF (last=0), then in_a=64'hFF00FF00FF00FF00 (last=1), in_b=0 for both.
   - Required: no out_valid after beat 1; out_all=4'b1111 and out_beats=2 two cycles after beat 2.
4. Backpressure, single mode:
   - out_ready=0 while three beats are offered.
   - Beats 1 and 2 are accepted (held in output and s1); in_ready=0 for beat 3.
   - Raise out_ready: beat-3 acceptance resumes and results emerge in order 1, 2, 3.
5. Reset mid-frame:
   - One accumulate beat with in_a all ones, then rst for 1 cycle.
   - Next single beat with in_a=in_b=0 -> out_all=4'b0000, all miss_idx=0, out_beats=1; nothing leaks from the aborted frame.
6. CNT_W=2, accumulate frame of 5 beats -> out_beats=3 (saturated); a mode toggle on beat 3 has no effect.
